// File: rtl/dpsk_pkg.sv
// Shared constants for the DPSK/BPSK test modem.
// Default timing targets a 12 MHz clock.
package dpsk_pkg;

    localparam int CARRIER_DIV_DEF = 30000;
    localparam int BIT_DIV_DEF     = 150000;

    localparam int MODE_BPSK = 0;
    localparam int MODE_DPSK = 1;

endpackage

// File: rtl/dpsk_demod.sv
// Receive path: coherent demodulation, optional differential decode,
// and a saturating bit-error counter against the transmitted bit.
module dpsk_demod
    import dpsk_pkg::*;
#(
    parameter int DIFF_EN = MODE_DPSK,
    parameter int ERR_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_mod,
    input  logic             i_car,
    input  logic             i_mid,
    input  logic             i_clr,
    input  logic             i_data,
    output logic             o_demod,
    output logic             o_dec,
    output logic [ERR_W-1:0] o_err
);

    logic             r_ref_d;
    logic             r_prev;
    logic             r_valid;
    logic             r_cmp;
    logic             r_demod;
    logic             r_dec;
    logic [ERR_W-1:0] r_err;
    logic             w_rx;

    assign w_rx = i_mod ^ r_ref_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_d <= 1'b0;
            r_prev  <= 1'b0;
            r_valid <= 1'b0;
            r_cmp   <= 1'b0;
            r_demod <= 1'b0;
            r_dec   <= 1'b0;
            r_err   <= '0;
        end else begin
            // Local reference lags carrier_0 by one cycle, like modulated.
            r_ref_d <= i_car;
            r_cmp   <= 1'b0;
            if (i_clr) begin
                r_prev  <= 1'b0;
                r_valid <= 1'b0;
            end else if (i_mid) begin
                r_demod <= w_rx;
                r_dec   <= (DIFF_EN == MODE_DPSK) ? (w_rx ^ r_prev) : w_rx;
                r_prev  <= w_rx;
                r_valid <= 1'b1;
                r_cmp   <= r_valid;
            end
            if (r_cmp && (r_dec != i_data) && (r_err != '1))
                r_err <= r_err + 1'b1;
        end
    end

    assign o_demod = r_demod;
    assign o_dec   = r_dec;
    assign o_err   = r_err;

endmodule

// File: rtl/dpsk_modem.sv
// DPSK/BPSK loopback modem: carrier, bit timing, pattern transmit,
// line coding and modulation; receive side lives in dpsk_demod.
module dpsk_modem
    import dpsk_pkg::*;
#(
    parameter int CARRIER_DIV = CARRIER_DIV_DEF,
    parameter int BIT_DIV     = BIT_DIV_DEF,
    parameter int PAT_W       = 8,
    parameter int DIFF_EN     = MODE_DPSK,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pattern_load,
    input  logic             err_inject,
    output logic             carrier_0,
    output logic             carrier_180,
    output logic             data_bit,
    output logic             encoded_bit,
    output logic             modulated,
    output logic             demodulated,
    output logic             decoded,
    output logic             bit_strobe,
    output logic             frame_sync,
    output logic [ERR_W-1:0] err_count
);

    localparam int CW = $clog2(CARRIER_DIV / 2);
    localparam int BW = $clog2(BIT_DIV);
    localparam int IW = $clog2(PAT_W);

    localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_MID  = BW'(BIT_DIV / 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(PAT_W - 1);

    logic [CW-1:0]    r_car_cnt;
    logic             r_car;
    logic [BW-1:0]    r_tmr;
    logic [IW-1:0]    r_idx;
    logic [PAT_W-1:0] r_pat;
    logic             r_data;
    logic             r_enc;
    logic             r_mod;
    logic             r_strobe;
    logic             r_fsync;

    logic             w_tick;
    logic             w_mid;
    logic             w_d;
    logic             w_enc;

    assign w_tick = en && (r_tmr == BIT_LAST);
    assign w_mid  = en && (r_tmr == BIT_MID);
    assign w_d    = r_pat[IDX_LAST - r_idx];
    // The differential reference is simply the last encoded symbol.
    assign w_enc  = (DIFF_EN == MODE_DPSK) ? (r_enc ^ w_d) : w_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_car_cnt <= '0;
            r_car     <= 1'b0;
        end else if (r_car_cnt == CAR_LAST) begin
            r_car_cnt <= '0;
            r_car     <= ~r_car;
        end else begin
            r_car_cnt <= r_car_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr    <= '0;
            r_idx    <= '0;
            r_pat    <= '0;
            r_data   <= 1'b0;
            r_enc    <= 1'b0;
            r_strobe <= 1'b0;
            r_fsync  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_fsync  <= 1'b0;
            // A load restarts the frame from phase zero and drops any tick.
            if (pattern_load) begin
                r_pat <= pattern;
                r_idx <= '0;
                r_tmr <= '0;
                r_enc <= 1'b0;
            end else if (en) begin
                r_tmr <= w_tick ? '0 : r_tmr + 1'b1;
                if (w_tick) begin
                    r_data   <= w_d;
                    r_enc    <= w_enc;
                    r_idx    <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    r_strobe <= 1'b1;
                    r_fsync  <= (r_idx == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mod <= 1'b0;
        else     r_mod <= r_car ^ r_enc ^ err_inject;
    end

    dpsk_demod #(
        .DIFF_EN (DIFF_EN),
        .ERR_W   (ERR_W)
    ) u_demod (
        .clk     (clk),
        .rst     (rst),
        .i_mod   (r_mod),
        .i_car   (r_car),
        .i_mid   (w_mid),
        .i_clr   (pattern_load),
        .i_data  (r_data),
        .o_demod (demodulated),
        .o_dec   (decoded),
        .o_err   (err_count)
    );

    assign carrier_0   = r_car;
    assign carrier_180 = ~r_car;
    assign data_bit    = r_data;
    assign encoded_bit = r_enc;
    assign modulated   = r_mod;
    assign bit_strobe  = r_strobe;
    assign frame_sync  = r_fsync;

endmodule

// File: tb/tb_dpsk_modem.sv
// Bench for dpsk_modem: DPSK, BPSK and 2-bit-counter BPSK builds run
// side by side against a bit-level model plus hand-computed literals.
module tb_dpsk_modem;

    localparam int CD = 4;
    localparam int BD = 16;
    localparam int P  = 8;

    localparam logic [P-1:0] PAT_A = 8'b10110110;
    localparam logic [P-1:0] PAT_B = 8'b01100101;
    localparam logic [P-1:0] PAT_C = 8'b11110000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         pattern_load = 1'b0;
    logic         err_inject = 1'b0;
    logic [P-1:0] pattern = '0;

    logic dp_c0, dp_c180, dp_d, dp_e, dp_m, dp_dm, dp_dec, dp_bs, dp_fs;
    logic bp_c0, bp_c180, bp_d, bp_e, bp_m, bp_dm, bp_dec, bp_bs, bp_fs;
    logic b2_c0, b2_c180, b2_d, b2_e, b2_m, b2_dm, b2_dec, b2_bs, b2_fs;
    logic [15:0] dp_err;
    logic [15:0] bp_err;
    logic [1:0]  b2_err;

    always #5 clk = ~clk;

    dpsk_modem #(.CARRIER_DIV(CD), .BIT_DIV(BD), .PAT_W(P),
                 .DIFF_EN(1), .ERR_W(16)) u_dp (
        .clk(clk), .rst(rst), .en(en), .pattern(pattern),
        .pattern_load(pattern_load), .err_inject(err_inject),
        .carrier_0(dp_c0), .carrier_180(dp_c180), .data_bit(dp_d),
        .encoded_bit(dp_e), .modulated(dp_m), .demodulated(dp_dm),
        .decoded(dp_dec), .bit_strobe(dp_bs), .frame_sync(dp_fs),
        .err_count(dp_err));

    dpsk_modem #(.CARRIER_DIV(CD), .BIT_DIV(BD), .PAT_W(P),
                 .DIFF_EN(0), .ERR_W(16)) u_bp (
        .clk(clk), .rst(rst), .en(en), .pattern(pattern),
        .pattern_load(pattern_load), .err_inject(err_inject),
        .carrier_0(bp_c0), .carrier_180(bp_c180), .data_bit(bp_d),
        .encoded_bit(bp_e), .modulated(bp_m), .demodulated(bp_dm),
        .decoded(bp_dec), .bit_strobe(bp_bs), .frame_sync(bp_fs),
        .err_count(bp_err));

    dpsk_modem #(.CARRIER_DIV(CD), .BIT_DIV(BD), .PAT_W(P),
                 .DIFF_EN(0), .ERR_W(2)) u_b2 (
        .clk(clk), .rst(rst), .en(en), .pattern(pattern),
        .pattern_load(pattern_load), .err_inject(err_inject),
        .carrier_0(b2_c0), .carrier_180(b2_c180), .data_bit(b2_d),
        .encoded_bit(b2_e), .modulated(b2_m), .demodulated(b2_dm),
        .decoded(b2_dec), .bit_strobe(b2_bs), .frame_sync(b2_fs),
        .err_count(b2_err));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Bit-level model: m = clocks since reset, n = enabled clocks since
    // load, k = bits sent since load.  Carrier phase and every bit event
    // follow from these counts by division.
    int       m, n, k, mids;
    logic [P-1:0] pat;
    logic     cur_d, cur_e, cur_eb;
    logic     exp_bs, exp_fs, mid_now;
    logic     mod_dp, mod_bp;
    logic     car_now;
    bit       dec_chk = 1'b1;

    always @(posedge clk) begin
        exp_bs  = 1'b0;
        exp_fs  = 1'b0;
        mid_now = 1'b0;
        if (rst) begin
            m = 0; n = 0; k = 0; mids = 0;
            pat = '0;
            cur_d = 1'b0; cur_e = 1'b0; cur_eb = 1'b0;
            mod_dp = 1'b0; mod_bp = 1'b0;
        end else begin
            car_now = 1'((m / (CD / 2)) % 2);
            mod_dp  = car_now ^ cur_e ^ err_inject;
            mod_bp  = car_now ^ cur_eb ^ err_inject;
            m++;
            if (pattern_load) begin
                pat = pattern;
                n = 0; k = 0; mids = 0;
                cur_e = 1'b0; cur_eb = 1'b0;
            end else if (en) begin
                if (n % BD == BD - 1) begin
                    cur_d  = pat[P - 1 - (k % P)];
                    cur_e  = cur_e ^ cur_d;
                    cur_eb = cur_d;
                    exp_bs = 1'b1;
                    exp_fs = (k % P == 0);
                    k++;
                end
                if (n % BD == BD / 2) begin
                    mids++;
                    mid_now = (mids > 1);
                end
                n++;
            end
        end
    end

    always @(negedge clk) begin
        logic ec;
        logic nec;
        ec  = 1'((m / (CD / 2)) % 2);
        nec = ~ec;
        check("carrier_0", dp_c0, ec);
        check("carrier_180", dp_c180, nec);
        check("bp_carrier_0", bp_c0, ec);
        check("bit_strobe", dp_bs, exp_bs);
        check("frame_sync", dp_fs, exp_fs);
        check("bp_bit_strobe", bp_bs, exp_bs);
        check("data_bit", dp_d, cur_d);
        check("bp_data_bit", bp_d, cur_d);
        check("dp_encoded", dp_e, cur_e);
        check("bp_encoded", bp_e, cur_eb);
        check("dp_modulated", dp_m, mod_dp);
        check("bp_modulated", bp_m, mod_bp);
        if (dec_chk && mid_now) begin
            check("dp_decoded", dp_dec, cur_d);
            check("dp_demod", dp_dm, cur_e);
            check("bp_decoded", bp_dec, cur_d);
            check("bp_demod", bp_dm, cur_d);
            check("b2_decoded", b2_dec, cur_d);
        end
    end

    task automatic tick(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic wait_strobe();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * BD && !ok; i++) begin
            @(negedge clk);
            if (dp_bs) ok = 1'b1;
        end
        if (!ok) check("strobe_timeout", 0, 1);
    endtask

    task automatic load(input logic [P-1:0] p);
        pattern      = p;
        pattern_load = 1'b1;
        @(negedge clk);
        pattern_load = 1'b0;
    endtask

    logic [7:0] dp_seq, bp_seq;

    initial begin
        tick(3);
        check("rst_carrier_0", dp_c0, 0);
        check("rst_carrier_180", dp_c180, 1);
        check("rst_data_bit", dp_d, 0);
        check("rst_err_count", dp_err, 0);
        rst = 1'b0;
        tick(3);

        // Three frames of pattern A with no channel errors
        load(PAT_A);
        en = 1'b1;
        dp_seq = '0;
        bp_seq = '0;
        for (int i = 0; i < 8; i++) begin
            wait_strobe();
            dp_seq = {dp_seq[6:0], dp_e};
            bp_seq = {bp_seq[6:0], bp_e};
        end
        check("dpsk_enc_seq", dp_seq, 8'b11011011);
        check("bpsk_enc_seq", bp_seq, 8'b10110110);
        for (int i = 0; i < 16; i++) wait_strobe();
        tick(BD / 2 + 2);
        check("clean_dp_err", dp_err, 0);
        check("clean_bp_err", bp_err, 0);
        check("clean_b2_err", b2_err, 0);

        // One bit window of channel inversion
        dec_chk = 1'b0;
        wait_strobe();
        err_inject = 1'b1;
        tick(BD);
        err_inject = 1'b0;
        for (int i = 0; i < 3; i++) wait_strobe();
        tick(BD / 2 + 2);
        check("one_bit_dp_err", dp_err, 2);
        check("one_bit_bp_err", bp_err, 1);
        check("one_bit_b2_err", b2_err, 1);

        // Four bit windows: the 2-bit counter must saturate, not wrap
        wait_strobe();
        err_inject = 1'b1;
        tick(4 * BD);
        err_inject = 1'b0;
        for (int i = 0; i < 3; i++) wait_strobe();
        tick(BD / 2 + 2);
        check("sat_b2_err", b2_err, 3);
        check("four_bit_bp_err", bp_err, 5);
        check("four_bit_dp_err", dp_err, 4);

        // Load landing on the bit tick: the tick is dropped
        load(PAT_A);
        dec_chk = 1'b1;
        for (int i = 0; i < 4 * BD && n != BD - 1; i++) @(negedge clk);
        check("align_before_tick", n, BD - 1);
        load(PAT_B);
        wait_strobe();
        check("load_wins_msb", dp_d, 0);
        check("load_wins_fsync", dp_fs, 1);
        for (int i = 0; i < 8; i++) wait_strobe();
        tick(BD / 2 + 2);
        check("retained_dp_err", dp_err, 4);
        check("held_b2_err", b2_err, 3);

        // Freeze, then load while disabled
        tick(5);
        en = 1'b0;
        tick(20);
        load(PAT_C);
        tick(10);
        en = 1'b1;
        wait_strobe();
        check("en_rise_msb", dp_d, 1);
        check("en_rise_fsync", dp_fs, 1);
        for (int i = 0; i < 9; i++) wait_strobe();
        tick(BD / 2 + 2);
        check("frozen_dp_err", dp_err, 4);

        // Asynchronous reset in the middle of a bit
        tick(5);
        #1 rst = 1'b1;
        #1;
        check("arst_carrier_0", dp_c0, 0);
        check("arst_carrier_180", dp_c180, 1);
        check("arst_data_bit", dp_d, 0);
        check("arst_encoded", dp_e, 0);
        check("arst_modulated", dp_m, 0);
        check("arst_demod", dp_dm, 0);
        check("arst_decoded", dp_dec, 0);
        check("arst_dp_err", dp_err, 0);
        check("arst_bp_err", bp_err, 0);
        check("arst_b2_err", b2_err, 0);
        tick(2);
        rst = 1'b0;
        wait_strobe();
        check("post_rst_bit", dp_d, 0);
        check("post_rst_fsync", dp_fs, 1);
        for (int i = 0; i < 3; i++) wait_strobe();
        tick(BD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dpsk_modem.md
DPSK_MODEM -- requirements
Module: dpsk_modem

Interface
REQ-001 Parameter CARRIER_DIV, default 30000, clk cycles per carrier period; even, >=4.
REQ-002 Parameter BIT_DIV, default 150000, clk cycles per data bit; >=8, multiple of CARRIER_DIV.
REQ-003 Parameter PAT_W, default 8, test-pattern length in bits; >=2.
REQ-004 Parameter DIFF_EN, default 1; 1 = DPSK (differential), 0 = plain BPSK.
REQ-005 Parameter ERR_W, default 16, bit-error counter width.
REQ-006 clk  in  1  system clock (12 MHz); the single clock; all state on posedge.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 en  in  1  bit-timer enable; carrier free-runs regardless.
REQ-009 pattern  in  PAT_W  pattern to transmit, sent MSB first.
REQ-010 pattern_load  in  1  one-cycle strobe capturing pattern.
REQ-011 err_inject  in  1  inverts the channel (modulated) while high.
REQ-012 carrier_0 / carrier_180  out  1 each  0 deg carrier and its exact complement.
REQ-013 data_bit, encoded_bit, modulated  out  1 each  TX bit, line-coded bit, channel signal.
REQ-014 demodulated, decoded  out  1 each  RX line-coded bit, recovered data bit.
REQ-015 bit_strobe  out  1  one-cycle pulse per new TX bit.
REQ-016 frame_sync  out  1  one-cycle pulse with bit_strobe when pattern index 0 is sent.
REQ-017 err_count  out  ERR_W  saturating count of decoded != data_bit.

Function
REQ-018 Carrier counter 0..CARRIER_DIV/2-1, wraps; carrier_0 toggles on wrap; carrier_180 == ~carrier_0 every cycle.
REQ-019 Bit timer 0..BIT_DIV-1 advances only when en=1; bit_tick = en && timer==BIT_DIV-1; en=0 freezes timer and all TX/RX bit state.
REQ-020 On bit_tick: data_bit <= pat_reg[PAT_W-1-idx]; idx wraps PAT_W-1 -> 0; bit_strobe=1 next cycle; frame_sync also if idx was 0.
REQ-021 Encoding on bit_tick: DIFF_EN=1 -> enc = ref XOR d, ref <= enc; DIFF_EN=0 -> enc = d; encoded_bit <= enc.
REQ-022 modulated registered: carrier_0 XOR encoded_bit XOR err_inject, one cycle behind carrier_0.
REQ-023 Local RX reference is carrier_0 delayed one cycle (aligned with modulated).
REQ-024 At timer == BIT_DIV/2 (mid-bit): rx = modulated XOR ref_d; demodulated <= rx; decoded <= DIFF_EN ? rx XOR prev_rx : rx; prev_rx <= rx.
REQ-025 Latency: decoded for a bit is valid BIT_DIV/2+1 cycles after its data_bit update, while data_bit still holds that bit.
REQ-026 One cycle after each mid-bit update, err_count increments if decoded != data_bit; saturates at 2^ERR_W-1, no wrap.
REQ-027 First mid-bit sample after reset or load is compare-masked (prev_rx invalid); err_count unchanged.
REQ-028 pattern_load: pat_reg <= pattern; idx, bit timer, ref, prev_rx <= 0; a coincident bit_tick is discarded (load wins); err_count retained.
REQ-029 pattern_load while en=0 is accepted; new pattern starts when en rises.

Reset
REQ-030 rst asserts asynchronously: all counters, idx, ref, prev_rx, pat_reg, err_count and every output <= 0, except carrier_180 = 1.
REQ-031 rst mid-bit aborts the bit; after release transmission restarts at pattern bit PAT_W-1 of an all-zero pat_reg until pattern_load.

Structure
REQ-032 Shared package dpsk_pkg holds default CARRIER_DIV/BIT_DIV values and DIFF_EN mode constants (MODE_BPSK=0, MODE_DPSK=1).
REQ-033 RX path (REQ-023..027) is one sub-module dpsk_demod; TX, carrier and timers stay in dpsk_modem.

Verification (CARRIER_DIV=4, BIT_DIV=16, PAT_W=8, pattern 8'b10110110)
REQ-034 DPSK, load, en=1: encoded_bit sequence 1,1,0,1,1,0,1,1; decoded tracks data_bit; err_count stays 0 over 3 frames.
REQ-035 DIFF_EN=0: encoded_bit == data_bit each bit; demodulated == decoded == data_bit; err_count 0.
REQ-036 DPSK, err_inject high for exactly one bit window: err_count ends at 2; BPSK build ends at 1.
REQ-037 ERR_W=2, err_inject held high in BPSK: err_count reaches 3 and holds at 3.
REQ-038 rst pulse mid-bit: all outputs 0, carrier_180=1, within the same cycle; pattern_load coincident with bit_tick -> next data_bit is pattern MSB.
